mul256_op_seq: RTL and testbench

- Command sequencer for the 64 x 260-bit operand memory and the 256-bit multiplier core.
- Accepts one command at a time: MUL (D <= A*B via the core) or COPY (D <= A).
- Reads operands through the memory op read port, runs the core, and writes the result back through the op write port.
- Obeys the memory's op_write/op_wready ownership handshake, so bus accesses to the memory stay live between operations.

---
 rtl/mul256_op_seq.sv | 154 +++++++++++++++
 tb/tb_mul256_op_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul256_op_seq.sv
// ============================================================================
//  mul256_op_seq
//  Command sequencer: MUL (D <= A*B) or COPY (D <= A) between the 64 x 260-bit
//  operand memory and the 256-bit multiplier core.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mul256_op_seq #(
    parameter int AW = 6,
    parameter int DW = 260
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [AW-1:0] cmd_a,
    input  logic [AW-1:0] cmd_b,
    input  logic [AW-1:0] cmd_d,
    output logic          busy,
    output logic          done,
    output logic          op_read,
    output logic [AW-1:0] op_raddr,
    input  logic [DW-1:0] op_rdata,
    output logic          op_write,
    output logic [AW-1:0] op_waddr,
    output logic [DW-1:0] op_wdata,
    input  logic          op_wready,
    output logic          core_start,
    output logic [DW-1:0] core_a,
    output logic [DW-1:0] core_b,
    input  logic          core_done,
    input  logic [DW-1:0] core_result
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_A      = 4'd1,
        RD_B      = 4'd2,
        CAP_B     = 4'd3,
        CAP_A     = 4'd4,
        START     = 4'd5,
        WAIT_CORE = 4'd6,
        WR        = 4'd7,
        DONE      = 4'd8
    } state_t;

    state_t          state;
    logic            is_copy;
    logic [AW-1:0]   b_addr;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   a_reg;
    logic [DW-1:0]   b_reg;
    logic [DW-1:0]   r_reg;

    assign busy     = (state != IDLE);
    assign core_a   = a_reg;
    assign core_b   = b_reg;
    assign op_wdata = r_reg;

    // Outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cmd_ready  <= 1'b1;
            done       <= 1'b0;
            op_read    <= 1'b0;
            op_write   <= 1'b0;
            core_start <= 1'b0;
            op_raddr   <= '0;
            op_waddr   <= '0;
            is_copy    <= 1'b0;
            b_addr     <= '0;
            d_addr     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            r_reg      <= '0;
        end else begin
            done       <= 1'b0;
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        is_copy   <= cmd_op;
                        b_addr    <= cmd_b;
                        d_addr    <= cmd_d;
                        op_read   <= 1'b1;
                        op_raddr  <= cmd_a;
                        cmd_ready <= 1'b0;
                        state     <= RD_A;
                    end
                end
                RD_A: begin
                    if (is_copy) begin
                        op_read <= 1'b0;
                        state   <= CAP_A;
                    end else begin
                        op_raddr <= b_addr;
                        state    <= RD_B;
                    end
                end
                RD_B: begin
                    a_reg   <= op_rdata;
                    op_read <= 1'b0;
                    state   <= CAP_B;
                end
                CAP_B: begin
                    b_reg      <= op_rdata;
                    core_start <= 1'b1;
                    state      <= START;
                end
                CAP_A: begin
                    r_reg    <= op_rdata;
                    op_write <= 1'b1;
                    op_waddr <= d_addr;
                    state    <= WR;
                end
                START: begin
                    state <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        r_reg    <= core_result;
                        op_write <= 1'b1;
                        op_waddr <= d_addr;
                        state    <= WR;
                    end
                end
                WR: begin
                    // Request stays asserted until the memory grants ownership.
                    if (op_wready) begin
                        op_write <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    op_read   <= 1'b0;
                    op_write  <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul256_op_seq.sv
// ============================================================================
//  tb_mul256_op_seq
//  Directed bench with an operand memory model and a fixed-latency core model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mul256_op_seq;

    localparam int AW = 6;
    localparam int DW = 260;
    localparam logic [DW-1:0] ALL1 = {DW{1'b1}};
    localparam logic [DW-1:0] PAT  = {4'h5, {8{32'hDEADBEEF}}};

    logic          clk;
    logic          rstn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_a;
    logic [AW-1:0] cmd_b;
    logic [AW-1:0] cmd_d;
    logic          busy;
    logic          done;
    logic          op_read;
    logic [AW-1:0] op_raddr;
    logic [DW-1:0] op_rdata;
    logic          op_write;
    logic [AW-1:0] op_waddr;
    logic [DW-1:0] op_wdata;
    logic          op_wready;
    logic          core_start;
    logic [DW-1:0] core_a;
    logic [DW-1:0] core_b;
    logic          core_done;
    logic [DW-1:0] core_result;

    logic [DW-1:0] mem [0:63];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;
    int            n_wr;
    int            n_start;
    logic [2:0]    ccnt;
    int            n_cmp;
    int            n_err;
    int            w0;
    int            s0;

    mul256_op_seq #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_d       (cmd_d),
        .busy        (busy),
        .done        (done),
        .op_read     (op_read),
        .op_raddr    (op_raddr),
        .op_rdata    (op_rdata),
        .op_write    (op_write),
        .op_waddr    (op_waddr),
        .op_wdata    (op_wdata),
        .op_wready   (op_wready),
        .core_start  (core_start),
        .core_a      (core_a),
        .core_b      (core_b),
        .core_done   (core_done),
        .core_result (core_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand memory: read data one cycle after op_read, write on op_write & op_wready.
    initial begin
        n_wr     = 0;
        op_rdata = '0;
    end
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (op_read) op_rdata <= mem[op_raddr];
        if (op_write && op_wready) begin
            mem[op_waddr] <= op_wdata;
            n_wr          <= n_wr + 1;
        end
    end

    // Core: done pulse four cycles after the start cycle; not reset by rstn.
    initial begin
        ccnt        = '0;
        core_done   = 1'b0;
        core_result = '0;
        n_start     = 0;
    end
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start) begin
            ccnt    <= 3'd3;
            n_start <= n_start + 1;
        end else if (ccnt != 0) begin
            ccnt <= ccnt - 3'd1;
            if (ccnt == 3'd1) begin
                core_done   <= 1'b1;
                core_result <= core_a * core_b;
            end
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, ".cmd_ready"}, DW'(cmd_ready), DW'(1));
        chk({tag, ".busy"}, DW'(busy), '0);
        chk({tag, ".done"}, DW'(done), '0);
        chk({tag, ".op_read"}, DW'(op_read), '0);
        chk({tag, ".op_write"}, DW'(op_write), '0);
        chk({tag, ".core_start"}, DW'(core_start), '0);
        chk({tag, ".op_raddr"}, DW'(op_raddr), '0);
        chk({tag, ".op_waddr"}, DW'(op_waddr), '0);
        chk({tag, ".op_wdata"}, op_wdata, '0);
        chk({tag, ".core_a"}, core_a, '0);
        chk({tag, ".core_b"}, core_b, '0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    // Presents a command in the current (idle) cycle; the next edge accepts it.
    task automatic issue(input logic op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] d, input string tag);
        chk({tag, ".ready_idle"}, DW'(cmd_ready), DW'(1));
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_d     = d;
        cmd_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_d = '0;
        op_wready = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        repeat (2) @(negedge clk);
        chk_rst("reset");
        preload(6'd1, DW'(5));
        preload(6'd2, DW'(7));
        preload(6'd10, ALL1);
        preload(6'd5, PAT);
        preload(6'd4, DW'(3));
        rstn = 1'b1;
        @(negedge clk);

        // MUL 1*2 -> 3, accept cycle T
        w0 = n_wr; s0 = n_start;
        issue(1'b0, 6'd1, 6'd2, 6'd3, "mul");
        @(negedge clk); cmd_valid = 1'b0;                                    // T+1
        chk("mul.rd_a", DW'({op_read, op_raddr}), DW'({1'b1, 6'd1}));
        chk("mul.busy_ready", DW'({busy, cmd_ready}), DW'(2'b10));
        @(negedge clk);                                                      // T+2
        chk("mul.rd_b", DW'({op_read, op_raddr}), DW'({1'b1, 6'd2}));
        @(negedge clk);                                                      // T+3
        chk("mul.no_rd_no_start", DW'({op_read, core_start}), '0);
        @(negedge clk);                                                      // T+4
        chk("mul.start", DW'(core_start), DW'(1));
        chk("mul.core_a", core_a, DW'(5));
        chk("mul.core_b", core_b, DW'(7));
        repeat (4) @(negedge clk);                                           // T+8 core_done
        chk("mul.no_write_before_result", DW'(op_write), '0);
        @(negedge clk);                                                      // T+9
        chk("mul.wr", DW'({op_write, op_waddr}), DW'({1'b1, 6'd3}));
        chk("mul.wdata", op_wdata, DW'(35));
        @(negedge clk);                                                      // T+10
        chk("mul.done", DW'({done, op_write}), DW'(2'b10));
        chk("mul.mem3", mem[3], DW'(35));
        chk("mul.nwrites", DW'(n_wr - w0), DW'(1));
        chk("mul.nstarts", DW'(n_start - s0), DW'(1));
        @(negedge clk);                                                      // T+11
        chk("mul.idle", DW'({done, cmd_ready, busy}), DW'(3'b010));

        // COPY 10 -> 20 with ownership already held
        issue(1'b1, 6'd10, 6'd0, 6'd20, "copy");
        @(negedge clk); cmd_valid = 1'b0;                                    // T+1
        chk("copy.rd_a", DW'({op_read, op_raddr}), DW'({1'b1, 6'd10}));
        @(negedge clk);                                                      // T+2
        chk("copy.cap_a", DW'({op_read, op_write}), '0);
        @(negedge clk);                                                      // T+3
        chk("copy.wr", DW'({op_write, op_waddr}), DW'({1'b1, 6'd20}));
        chk("copy.wdata", op_wdata, ALL1);
        @(negedge clk);                                                      // T+4
        chk("copy.done", DW'(done), DW'(1));
        chk("copy.mem20", mem[20], ALL1);

        // WR stall: COPY 5 -> 6, ownership withheld for 5 cycles
        @(negedge clk);
        op_wready = 1'b0;
        w0 = n_wr;
        issue(1'b1, 6'd5, 6'd0, 6'd6, "stall");
        @(negedge clk); cmd_valid = 1'b0;
        repeat (2) @(negedge clk);                                           // T+3
        for (int i = 0; i < 5; i++) begin
            chk("stall.wr_hold", DW'({op_write, op_waddr, done}), DW'({1'b1, 6'd6, 1'b0}));
            chk("stall.wdata_hold", op_wdata, PAT);
            chk("stall.no_commit", DW'(n_wr - w0), '0);
            @(negedge clk);
        end
        chk("stall.still_req", DW'(op_write), DW'(1));
        op_wready = 1'b1;
        @(negedge clk);
        chk("stall.done", DW'({done, op_write}), DW'(2'b10));
        chk("stall.one_write", DW'(n_wr - w0), DW'(1));
        chk("stall.mem6", mem[6], PAT);

        // Back-to-back: COPY 5->21 then, with valid held, COPY 21->22
        @(negedge clk);
        issue(1'b1, 6'd5, 6'd0, 6'd21, "b2b");
        @(negedge clk);                                                      // T+1
        cmd_a = 6'd21; cmd_d = 6'd22;
        for (int i = 1; i <= 4; i++) begin
            chk("b2b.not_ready", DW'(cmd_ready), '0);
            if (i < 4) @(negedge clk);
        end
        chk("b2b.done1", DW'(done), DW'(1));                                 // T+4
        @(negedge clk);                                                      // T+5
        chk("b2b.ready_again", DW'(cmd_ready), DW'(1));
        @(negedge clk); cmd_valid = 1'b0;                                    // T+6
        chk("b2b.rd_second", DW'({op_read, op_raddr}), DW'({1'b1, 6'd21}));
        repeat (3) @(negedge clk);                                           // T+9
        chk("b2b.done2", DW'(done), DW'(1));
        chk("b2b.mem22", mem[22], PAT);

        // Reset during WAIT_CORE
        @(negedge clk);
        w0 = n_wr;
        issue(1'b0, 6'd1, 6'd2, 6'd7, "rst");
        @(negedge clk); cmd_valid = 1'b0;
        repeat (5) @(negedge clk);                                           // T+6 WAIT_CORE
        chk("rst.in_wait", DW'({busy, op_write}), DW'(2'b10));
        rstn = 1'b0;
        @(negedge clk);                                                      // T+7
        chk_rst("rst.mid");
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin                                    // core_done at T+8
            @(negedge clk);
            chk("rst.quiet", DW'({op_write, done, busy, cmd_ready}), DW'(4'b0001));
        end
        chk("rst.no_write", DW'(n_wr - w0), '0);
        chk("rst.core_a", core_a, '0);

        // Aliasing MUL 4*4 -> 4
        issue(1'b0, 6'd4, 6'd4, 6'd4, "alias");
        @(negedge clk); cmd_valid = 1'b0;
        repeat (3) @(negedge clk);                                           // T+4
        chk("alias.core_a", core_a, DW'(3));
        chk("alias.core_b", core_b, DW'(3));
        repeat (5) @(negedge clk);                                           // T+9
        chk("alias.wr", DW'({op_write, op_waddr}), DW'({1'b1, 6'd4}));
        @(negedge clk);                                                      // T+10
        chk("alias.done", DW'(done), DW'(1));
        chk("alias.mem4", mem[4], DW'(9));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
